// File: rtl/pipelined_control_if.sv
// Control-bus bundle between the IF/ID boundary and pipelined_control.
// With PIPELINED_CONTROL_ILLEGAL_EN defined, the bundle also carries ex_illegal_o.
interface pipelined_control_if #(
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned REG_AW  = 5
);
  logic               id_valid_i;
  logic [6:0]         opcode_i;
  logic [2:0]         func3_i;
  logic [REG_AW-1:0]  rs1_i;
  logic [REG_AW-1:0]  rs2_i;
  logic [REG_AW-1:0]  rd_i;
  logic               stall_i;
  logic               flush_i;

  logic               hazard_stall_o;
  logic               ex_valid_o;
  logic               ex_alusrc_o;
  logic               ex_jump_o;
  logic               ex_jalr_o;
  logic               ex_branch_o;
  logic               ex_auipc_o;
  logic [ALUOP_W-1:0] ex_aluop_o;
  logic [REG_AW-1:0]  ex_rd_o;
  logic [REG_AW-1:0]  mem_rd_o;
  logic [REG_AW-1:0]  wb_rd_o;
  logic               ex_regwrite_o;
  logic               mem_regwrite_o;
  logic               mem_valid_o;
  logic               mem_memread_o;
  logic               mem_memwrite_o;
  logic [1:0]         mem_ltype_o;
  logic [1:0]         mem_stype_o;
  logic               wb_valid_o;
  logic               wb_regwrite_o;
  logic               wb_memtoreg_o;
`ifdef PIPELINED_CONTROL_ILLEGAL_EN
  logic               ex_illegal_o;
`endif

  modport master (
    output id_valid_i, opcode_i, func3_i, rs1_i, rs2_i, rd_i, stall_i, flush_i,
`ifdef PIPELINED_CONTROL_ILLEGAL_EN
    input  ex_illegal_o,
`endif
    input  hazard_stall_o, ex_valid_o, ex_alusrc_o, ex_jump_o, ex_jalr_o,
           ex_branch_o, ex_auipc_o, ex_aluop_o, ex_rd_o, mem_rd_o, wb_rd_o,
           ex_regwrite_o, mem_regwrite_o, mem_valid_o, mem_memread_o,
           mem_memwrite_o, mem_ltype_o, mem_stype_o, wb_valid_o,
           wb_regwrite_o, wb_memtoreg_o
  );

  modport slave (
    input  id_valid_i, opcode_i, func3_i, rs1_i, rs2_i, rd_i, stall_i, flush_i,
`ifdef PIPELINED_CONTROL_ILLEGAL_EN
    output ex_illegal_o,
`endif
    output hazard_stall_o, ex_valid_o, ex_alusrc_o, ex_jump_o, ex_jalr_o,
           ex_branch_o, ex_auipc_o, ex_aluop_o, ex_rd_o, mem_rd_o, wb_rd_o,
           ex_regwrite_o, mem_regwrite_o, mem_valid_o, mem_memread_o,
           mem_memwrite_o, mem_ltype_o, mem_stype_o, wb_valid_o,
           wb_regwrite_o, wb_memtoreg_o
  );
endinterface

// File: rtl/pipelined_control.sv
// RV32I control decode in ID plus ID/EX, EX/MEM, MEM/WB control registers with stall/flush/load-use.
// Optional: PIPELINED_CONTROL_ILLEGAL_EN adds ex_illegal_o for illegal ID encodings.
module pipelined_control #(
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned REG_AW  = 5
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_control_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(5'b00001);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(5'b00010);
  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(5'b01010);
  localparam logic [ALUOP_W-1:0] ALU_BR  = ALUOP_W'(5'b01011);

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               alusrc;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               jump;
    logic               jalr;
    logic               branch;
    logic               auipc;
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         ltype;
    logic [1:0]         stype;
    logic [REG_AW-1:0]  rd;
`ifdef PIPELINED_CONTROL_ILLEGAL_EN
    logic               illegal;
`endif
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic              memread;
    logic              memwrite;
    logic [1:0]        ltype;
    logic [1:0]        stype;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  idex_t  dec;
  idex_t  ex_q;
  exmem_t mem_q;
  memwb_t wb_q;
  logic   use_rs1;
  logic   use_rs2;
  logic   hazard;

  function automatic logic [1:0] access_size(input logic [2:0] f3);
    case (f3)
      3'b001:  return 2'b01;
      3'b010:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (bus.id_valid_i) begin
      dec.valid = 1'b1;
      dec.rd    = bus.rd_i;
      use_rs1   = 1'b1;
      case (bus.opcode_i)
        OP_R: begin
          dec.regwrite = 1'b1; dec.aluop = ALU_R; use_rs2 = 1'b1;
        end
        OP_IALU: begin
          dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_ADD;
        end
        OP_LOAD: begin
          dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.memread = 1'b1;
          dec.memtoreg = 1'b1; dec.aluop = ALU_ADD;
          dec.ltype    = access_size(bus.func3_i);
`ifdef PIPELINED_CONTROL_ILLEGAL_EN
          dec.illegal  = (bus.func3_i > 3'b010);
`endif
        end
        OP_STORE: begin
          dec.alusrc = 1'b1; dec.memwrite = 1'b1; dec.aluop = ALU_ADD;
          dec.stype  = access_size(bus.func3_i); use_rs2 = 1'b1;
`ifdef PIPELINED_CONTROL_ILLEGAL_EN
          dec.illegal = (bus.func3_i > 3'b010);
`endif
        end
        OP_JAL: begin
          dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.jump = 1'b1;
          dec.aluop = ALU_ADD; use_rs1 = 1'b0;
        end
        OP_JALR: begin
          dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.jalr = 1'b1; dec.aluop = ALU_ADD;
        end
        OP_BRANCH: begin
          dec.branch = 1'b1; dec.aluop = ALU_BR; use_rs2 = 1'b1;
        end
        OP_LUI: begin
          dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = ALU_LUI; use_rs1 = 1'b0;
        end
        OP_AUIPC: begin
          dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.auipc = 1'b1;
          dec.aluop = ALU_ADD; use_rs1 = 1'b0;
        end
        default: begin
          // Unknown opcode enters as a bubble; only the illegal flag survives.
          dec     = '0;
          use_rs1 = 1'b0;
`ifdef PIPELINED_CONTROL_ILLEGAL_EN
          dec.illegal = 1'b1;
`endif
        end
      endcase
    end
  end

  always_comb begin
    hazard = ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
             ((use_rs1 && (ex_q.rd == bus.rs1_i)) || (use_rs2 && (ex_q.rd == bus.rs2_i))) &&
             dec.valid && !bus.stall_i && !bus.flush_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.stall_i) begin
      ex_q  <= (bus.flush_i || hazard) ? '0 : dec;
      mem_q <= '{valid: ex_q.valid, regwrite: ex_q.regwrite, memtoreg: ex_q.memtoreg,
                 memread: ex_q.memread, memwrite: ex_q.memwrite, ltype: ex_q.ltype,
                 stype: ex_q.stype, rd: ex_q.rd};
      wb_q  <= '{valid: mem_q.valid, regwrite: mem_q.regwrite,
                 memtoreg: mem_q.memtoreg, rd: mem_q.rd};
    end
  end

  assign bus.hazard_stall_o = hazard;
  assign bus.ex_valid_o     = ex_q.valid;
  assign bus.ex_alusrc_o    = ex_q.alusrc;
  assign bus.ex_jump_o      = ex_q.jump;
  assign bus.ex_jalr_o      = ex_q.jalr;
  assign bus.ex_branch_o    = ex_q.branch;
  assign bus.ex_auipc_o     = ex_q.auipc;
  assign bus.ex_aluop_o     = ex_q.aluop;
  assign bus.ex_rd_o        = ex_q.rd;
  assign bus.ex_regwrite_o  = ex_q.regwrite;
  assign bus.mem_valid_o    = mem_q.valid;
  assign bus.mem_regwrite_o = mem_q.regwrite;
  assign bus.mem_memread_o  = mem_q.memread;
  assign bus.mem_memwrite_o = mem_q.memwrite;
  assign bus.mem_ltype_o    = mem_q.ltype;
  assign bus.mem_stype_o    = mem_q.stype;
  assign bus.mem_rd_o       = mem_q.rd;
  assign bus.wb_valid_o     = wb_q.valid;
  assign bus.wb_regwrite_o  = wb_q.regwrite;
  assign bus.wb_memtoreg_o  = wb_q.memtoreg;
  assign bus.wb_rd_o        = wb_q.rd;
`ifdef PIPELINED_CONTROL_ILLEGAL_EN
  assign bus.ex_illegal_o   = ex_q.illegal;
`endif
endmodule
